bp_be_dcache_wbuf_drain: RTL

- Sits directly downstream of the dcache write buffer. Consumes its head entry through the wbuf valid/yumi handshake and retires stores into the banked data memory.
- Holds one entry in a coalescing register. Consecutive stores to the same word and way merge bytewise before the single data-mem write.
- Reports whether it is empty, and whether the held entry matches an LCE snoop.

---
 rtl/bp_be_dcache_wbuf_drain.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bp_be_dcache_wbuf_drain.sv
// Drains the dcache write buffer head into the banked data memory through a single
// coalescing register; same-word, same-way stores merge bytewise before one write.
module bp_be_dcache_wbuf_drain #(
   parameter int data_width_p  = 64,
   parameter int paddr_width_p = 56,
   parameter int ways_p        = 8,
   parameter int sets_p        = 64,
   parameter int timeout_p     = 4,
   localparam int mask_width_lp   = data_width_p / 8,
   localparam int way_id_width_lp = $clog2(ways_p),
   localparam int index_width_lp  = $clog2(sets_p),
   localparam int byte_offset_lp  = $clog2(mask_width_lp),
   localparam int age_width_lp    = $clog2(timeout_p + 1),
   localparam int entry_width_lp  = paddr_width_p + way_id_width_lp + data_width_p + mask_width_lp,
   localparam int dmem_addr_width_lp = index_width_lp + way_id_width_lp
) (
   input  logic                          clk_i,
   input  logic                          reset_i,

   input  logic                          wbuf_v_i,
   input  logic [entry_width_lp-1:0]     wbuf_entry_i,
   output logic                          wbuf_yumi_o,

   input  logic                          flush_i,

   output logic                          data_mem_v_o,
   output logic [dmem_addr_width_lp-1:0] data_mem_addr_o,
   output logic [ways_p-1:0]             data_mem_bank_o,
   output logic [data_width_p-1:0]       data_mem_data_o,
   output logic [mask_width_lp-1:0]      data_mem_mask_o,
   input  logic                          data_mem_yumi_i,

   output logic                          empty_o,

   input  logic [index_width_lp-1:0]     lce_snoop_index_i,
   input  logic [way_id_width_lp-1:0]    lce_snoop_way_i,
   output logic                          lce_snoop_match_o
);

   // Entry layout, MSB first: {paddr, way_id, data, mask}
   logic [paddr_width_p-1:0]   wbuf_paddr, hold_paddr;
   logic [way_id_width_lp-1:0] wbuf_way, hold_way;
   logic [data_width_p-1:0]    wbuf_data, hold_data, merged_data;
   logic [mask_width_lp-1:0]   wbuf_mask, hold_mask;

   logic                       hold_v_r;
   logic [entry_width_lp-1:0]  hold_entry_r;
   logic [age_width_lp-1:0]    age_r;

   logic [way_id_width_lp-1:0] hold_word;
   logic [index_width_lp-1:0]  hold_index;
   logic match, force_wr, grant, merge, load;
   logic unused_offset_bits;

   assign wbuf_paddr = wbuf_entry_i[entry_width_lp-1 -: paddr_width_p];
   assign wbuf_way   = wbuf_entry_i[data_width_p+mask_width_lp +: way_id_width_lp];
   assign wbuf_data  = wbuf_entry_i[mask_width_lp +: data_width_p];
   assign wbuf_mask  = wbuf_entry_i[0 +: mask_width_lp];

   assign hold_paddr = hold_entry_r[entry_width_lp-1 -: paddr_width_p];
   assign hold_way   = hold_entry_r[data_width_p+mask_width_lp +: way_id_width_lp];
   assign hold_data  = hold_entry_r[mask_width_lp +: data_width_p];
   assign hold_mask  = hold_entry_r[0 +: mask_width_lp];

   assign hold_word  = hold_paddr[byte_offset_lp +: way_id_width_lp];
   assign hold_index = hold_paddr[byte_offset_lp+way_id_width_lp +: index_width_lp];

   // Byte offsets inside a word never affect coalescing or addressing.
   assign unused_offset_bits = ^{wbuf_paddr[byte_offset_lp-1:0], hold_paddr[byte_offset_lp-1:0]};

   assign match = wbuf_v_i & hold_v_r
                & (wbuf_paddr[paddr_width_p-1:byte_offset_lp] == hold_paddr[paddr_width_p-1:byte_offset_lp])
                & (wbuf_way == hold_way);

   assign force_wr = hold_v_r & ((wbuf_v_i & ~match)
                                 | (age_r == age_width_lp'(timeout_p))
                                 | flush_i);

   // A yumi from memory without an outstanding request is ignored.
   assign grant = force_wr & data_mem_yumi_i;

   assign wbuf_yumi_o = wbuf_v_i & (~hold_v_r | (match & ~force_wr) | grant);
   assign merge       = match & ~force_wr & wbuf_yumi_o;
   assign load        = wbuf_yumi_o & ~merge;

   always_comb begin
      merged_data = hold_data;
      for (int b = 0; b < mask_width_lp; b++) begin
         if (wbuf_mask[b]) merged_data[8*b +: 8] = wbuf_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hold_v_r <= 1'b0;
         age_r    <= '0;
      end else if (merge) begin
         hold_entry_r <= {hold_paddr, hold_way, merged_data, hold_mask | wbuf_mask};
         age_r        <= '0;
      end else if (load) begin
         // A same-cycle grant has already written the old word; the new entry starts fresh.
         hold_entry_r <= wbuf_entry_i;
         hold_v_r     <= 1'b1;
         age_r        <= '0;
      end else if (grant) begin
         hold_v_r <= 1'b0;
         age_r    <= '0;
      end else if (hold_v_r && (age_r != age_width_lp'(timeout_p))) begin
         age_r <= age_r + 1'b1;
      end
   end

   assign data_mem_v_o    = force_wr;
   assign data_mem_addr_o = {hold_index, hold_word};
   assign data_mem_bank_o = ways_p'(1) << (hold_word ^ hold_way);
   assign data_mem_data_o = hold_data;
   assign data_mem_mask_o = hold_mask;

   assign empty_o           = ~hold_v_r;
   assign lce_snoop_match_o = hold_v_r & (hold_index == lce_snoop_index_i)
                            & (hold_way == lce_snoop_way_i);

endmodule
